// File: rtl/bn_mem_host.sv
// bn_mem_host: host-side initiator and memory responder for a big-number core.
// Streams operands x1,x2 into a word RAM, pulses the core start, serves the
// core's combinational read / clocked write port, then streams out x3.
// Optional build macro: BN_MEM_TIMEOUT_EN adds a RUN-state watchdog that
// aborts with an error pulse after TIMEOUT cycles without i_core_done.
module bn_mem_host #(
    parameter int ADRBW   = 20,
    parameter int WRDBW   = 16,
    parameter int VARBW   = 16,
    parameter int DEPTH   = 1024,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [VARBW-1:0] i_len_x1,
    input  logic [VARBW-1:0] i_len_x2,
    input  logic             i_in_valid,
    input  logic [WRDBW-1:0] i_in_data,
    output logic             o_in_ready,
    output logic             o_out_valid,
    output logic [WRDBW-1:0] o_out_data,
    output logic             o_out_last,
    input  logic             i_out_ready,
    output logic             o_core_valid,
    output logic [ADRBW-1:0] o_core_x1addr,
    output logic [ADRBW-1:0] o_core_x2addr,
    output logic [ADRBW-1:0] o_core_x3addr,
    input  logic [ADRBW-1:0] i_core_addr,
    input  logic             i_core_wen,
    input  logic [WRDBW-1:0] i_core_wdata,
    output logic [WRDBW-1:0] o_core_rdata,
    input  logic [VARBW-1:0] i_core_varsize_x3,
    input  logic             i_core_done,
    output logic             o_busy,
    output logic             o_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [VARBW+1:0] DEPTH_W = (VARBW+2)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_DUMP} state_t;

    state_t           state, state_next;
    logic             err_next;
    logic [VARBW-1:0] len_x1, len_x2, n_words, out_cnt;
    logic [VARBW:0]   tot, wptr;
    logic [ADRBW-1:0] rptr;
    logic             out_valid;

    logic [WRDBW-1:0] mem [DEPTH];

    // Handshakes only count while the matching ready is asserted.
    logic           cmd_hs, in_hs, out_hs, out_last, cmd_bad;
    logic [VARBW:0] tot_next;

    assign cmd_hs   = i_cmd_valid && (state == S_IDLE);
    assign in_hs    = i_in_valid && (state == S_LOAD);
    assign out_hs   = out_valid && i_out_ready;
    assign out_last = out_valid && (out_cnt == n_words - VARBW'(1));
    assign tot_next = {1'b0, i_len_x1} + {1'b0, i_len_x2};
    // x1..x3 must all fit: worst-case x3 is as long as x1+x2.
    assign cmd_bad  = (i_len_x1 == '0) || (i_len_x2 == '0) || ({tot_next, 1'b0} > DEPTH_W);

`ifdef BN_MEM_TIMEOUT_EN
    logic [31:0] tcnt;
    logic        tmo;
    assign tmo = (tcnt == 32'(TIMEOUT - 1));
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state and error-pulse decision.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latches).
        state_next = state;
        err_next   = 1'b0;
        unique case (state)
            S_IDLE: if (cmd_hs) begin
                if (cmd_bad) err_next   = 1'b1;
                else         state_next = S_LOAD;
            end
            S_LOAD:  if (in_hs && (wptr == tot - (VARBW+1)'(1))) state_next = S_START;
            S_START: state_next = S_RUN;
            S_RUN: begin
                if (i_core_done) begin
                    if (i_core_varsize_x3 == '0) begin
                        err_next   = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_DUMP;
                    end
                end
`ifdef BN_MEM_TIMEOUT_EN
                else if (tmo) begin
                    err_next   = 1'b1;
                    state_next = S_IDLE;
                end
`endif
            end
            S_DUMP:  if (out_hs && out_last) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Lengths, pointers, output-word counter and registered flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_x1    <= '0;
            len_x2    <= '0;
            tot       <= '0;
            wptr      <= '0;
            rptr      <= '0;
            n_words   <= '0;
            out_cnt   <= '0;
            out_valid <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            if (cmd_hs) begin
                len_x1 <= i_len_x1;
                len_x2 <= i_len_x2;
                tot    <= tot_next;
                wptr   <= '0;
            end
            if (in_hs) wptr <= wptr + (VARBW+1)'(1);
            if ((state == S_RUN) && i_core_done) begin
                n_words <= i_core_varsize_x3;
                rptr    <= ADRBW'(tot);
                out_cnt <= '0;
            end
            if (out_hs) begin
                rptr    <= rptr + ADRBW'(1);
                out_cnt <= out_cnt + VARBW'(1);
            end
            out_valid <= (state_next == S_DUMP);
            o_err     <= err_next;
        end
    end

`ifdef BN_MEM_TIMEOUT_EN
    // Watchdog: cleared on entry to RUN, counts every RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                tcnt <= '0;
        else if (state == S_START) tcnt <= '0;
        else if (state == S_RUN)   tcnt <= tcnt + 32'd1;
    end
`endif

    // Single RAM write port shared by operand loading and core writes.
    always_ff @(posedge clk) begin
        // NOTE: RAM has no reset; contents are undefined until written.
        if (in_hs)
            mem[wptr[AW-1:0]] <= i_in_data;
        else if ((state == S_RUN) && i_core_wen)
            mem[i_core_addr[AW-1:0]] <= i_core_wdata;
    end

    assign o_core_rdata  = mem[i_core_addr[AW-1:0]];
    assign o_out_data    = mem[rptr[AW-1:0]];
    assign o_out_valid   = out_valid;
    assign o_out_last    = out_last;
    assign o_cmd_ready   = (state == S_IDLE);
    assign o_in_ready    = (state == S_LOAD);
    assign o_core_valid  = (state == S_START);
    assign o_busy        = (state != S_IDLE);
    assign o_core_x1addr = '0;
    assign o_core_x2addr = ADRBW'(len_x1);
    assign o_core_x3addr = ADRBW'(tot);

    // Address bits above the RAM depth are intentionally dropped (mod DEPTH).
    logic unused_bits;
    assign unused_bits = ^{i_core_addr[ADRBW-1:AW], rptr[ADRBW-1:AW], wptr[VARBW:AW],
                           len_x2, 32'(TIMEOUT)};

endmodule

// File: tb/tb_bn_mem_host.sv
// Directed self-checking bench for bn_mem_host with a behavioural core model.
module tb_bn_mem_host;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic [15:0] i_len_x1 = '0, i_len_x2 = '0;
    logic        i_in_valid = 1'b0;
    logic [15:0] i_in_data = '0;
    logic        o_in_ready, o_out_valid, o_out_last;
    logic [15:0] o_out_data;
    logic        i_out_ready = 1'b0;
    logic        o_core_valid;
    logic [19:0] o_core_x1addr, o_core_x2addr, o_core_x3addr;
    logic [19:0] i_core_addr = '0;
    logic        i_core_wen = 1'b0;
    logic [15:0] i_core_wdata = '0;
    logic [15:0] o_core_rdata;
    logic [15:0] i_core_varsize_x3 = '0;
    logic        i_core_done = 1'b0;
    logic        o_busy, o_err;

    int checks = 0, failures = 0, pulses = 0;
    logic [15:0] op [6] = '{16'ha836, 16'h5cb4, 16'h000b, 16'h0fcb, 16'h334f, 16'hdeac};

    bn_mem_host #(.TIMEOUT(100)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_len_x1(i_len_x1), .i_len_x2(i_len_x2),
        .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
        .o_out_valid(o_out_valid), .o_out_data(o_out_data), .o_out_last(o_out_last),
        .i_out_ready(i_out_ready),
        .o_core_valid(o_core_valid), .o_core_x1addr(o_core_x1addr),
        .o_core_x2addr(o_core_x2addr), .o_core_x3addr(o_core_x3addr),
        .i_core_addr(i_core_addr), .i_core_wen(i_core_wen), .i_core_wdata(i_core_wdata),
        .o_core_rdata(o_core_rdata), .i_core_varsize_x3(i_core_varsize_x3),
        .i_core_done(i_core_done), .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    // Count start pulses, sampled away from the active edge.
    always @(negedge clk) if (o_core_valid) pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_cmd(input logic [15:0] l1, input logic [15:0] l2);
        i_cmd_valid = 1'b1; i_len_x1 = l1; i_len_x2 = l2;
        @(negedge clk);
        i_cmd_valid = 1'b0;
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            i_in_valid = 1'b1; i_in_data = op[i];
            @(negedge clk);
        end
        i_in_valid = 1'b0;
    endtask

    // Core model: writes n words val0.. at base, then reports done with length n.
    task automatic core_run(input int base, input int n, input logic [15:0] val0, input bit rdw);
        for (int i = 0; i < n; i++) begin
            i_core_addr = 20'(base + i); i_core_wen = 1'b1; i_core_wdata = val0 + 16'(i);
            if (rdw && i == 0) check("rdw_old", o_core_rdata, 16'h0001);
            @(negedge clk);
            if (rdw && i == 0) check("rdw_new", o_core_rdata, val0);
        end
        i_core_wen = 1'b0; i_core_varsize_x3 = 16'(n); i_core_done = 1'b1;
        @(negedge clk);
        i_core_done = 1'b0;
    endtask

    task automatic collect(input int n, input logic [15:0] val0, input bit stall);
        int got = 0, cyc = 0;
        bit rdy;
        while (got < n && cyc < 200) begin
            rdy = stall ? (cyc % 3 == 0) : 1'b1;
            i_out_ready = rdy;
            if (o_out_valid) begin
                check(rdy ? "out_data" : "hold_data", o_out_data, val0 + 16'(got));
                check(rdy ? "out_last" : "hold_last", o_out_last, (got == n - 1));
                if (rdy) got++;
            end
            cyc++;
            @(negedge clk);
        end
        i_out_ready = 1'b0;
        if (got != n) check("collect_timeout", got, n);
        check("out_valid_end", o_out_valid, 1'b0);
        check("cmd_ready_end", o_cmd_ready, 1'b1);
    endtask

    task automatic full_load();
        pulses = 0;
        do_cmd(16'd3, 16'd3);
        check("in_ready_load", o_in_ready, 1'b1);
        load(6);
        repeat (2) @(negedge clk);
        check("start_pulses", pulses, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", o_cmd_ready, 1'b1);
        check("rst_busy", o_busy, 1'b0);
        check("rst_flags", {o_core_valid, o_out_valid, o_out_last, o_err}, 4'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: operand load and start
        full_load();
        check("x1addr", o_core_x1addr, 20'd0);
        check("x2addr", o_core_x2addr, 20'd3);
        check("x3addr", o_core_x3addr, 20'd6);
        i_core_addr = 20'd4;
        #1 check("rdata_addr4", o_core_rdata, 16'h334f);
        check("busy_run", o_busy, 1'b1);

        // 2: core writes result, stream out without stalls
        core_run(6, 6, 16'h0001, 1'b0);
        collect(6, 16'h0001, 1'b0);

        // 3: repeat with stalled downstream and a read-during-write probe
        full_load();
        core_run(6, 6, 16'h0011, 1'b1);
        collect(6, 16'h0011, 1'b1);

        // 4: rejected commands
        do_cmd(16'd0, 16'd3);
        check("err_len0", o_err, 1'b1);
        check("in_ready_len0", o_in_ready, 1'b0);
        check("cmd_ready_len0", o_cmd_ready, 1'b1);
        @(negedge clk);
        check("err_pulse_end", o_err, 1'b0);
        do_cmd(16'd300, 16'd300);
        check("err_too_big", o_err, 1'b1);
        @(negedge clk);
        do_cmd(16'd256, 16'd256);
        check("err_boundary", o_err, 1'b0);
        check("in_ready_boundary", o_in_ready, 1'b1);

        // 5: reset in the middle of a load
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_cmd(16'd3, 16'd3);
        load(2);
        rst_n = 1'b0;
        #1 check("rst_mid_busy", o_busy, 1'b0);
        check("rst_mid_ready", o_cmd_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        full_load();
        i_core_addr = 20'd5;
        #1 check("rdata_after_rst", o_core_rdata, 16'hdeac);

        // 6: core never finishes
`ifdef BN_MEM_TIMEOUT_EN
        begin
            int cyc = 0;
            while (!o_err && cyc < 300) begin
                @(negedge clk);
                cyc++;
            end
            check("timeout_err", o_err, 1'b1);
            check("timeout_idle", o_busy, 1'b0);
        end
`else
        repeat (1000) @(negedge clk);
        check("no_timeout_busy", o_busy, 1'b1);
`endif
        rst_n = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
